exec_pipe: RTL and testbench
============================

Name: exec_pipe

Overview:
- Parametrised single-issue execution pipeline: internal register file, integer ALU, iterative multiplier, status flags.
- Successor to the fixed-width RF/ALU datapath pairing. Generalised in word width and register count.
- Adds a valid/ready issue handshake, a writeback stage with operand/flag forwarding, and a multi-cycle multiply FSM.
- Sits between the instruction decoder (issue side) and the flag/debug consumers.

Parameters:
- WORD_WIDTH, 8, datapath width in bits; must be ≥4 and a power of two.
- ADDRESS_WIDTH, 3, register address width; register count = 2**ADDRESS_WIDTH.

Ports:
- clk_i  in  1  clock, all state on rising edge
- arst_i  in  1  asynchronous active-low reset
- issue_valid_i  in  1  op presented
- issue_ready_o  out  1  pipe can accept
- op_i  in  4  opcode (see Behaviour)
- rd_i  in  ADDRESS_WIDTH  destination register
- ra_i  in  ADDRESS_WIDTH  source A
- rb_i  in  ADDRESS_WIDTH  source B
- imm_i  in  WORD_WIDTH  immediate
- use_imm_i  in  1  B operand = imm_i instead of R[rb_i]
- wb_valid_o  out  1  writeback this cycle
- wb_addr_o  out  ADDRESS_WIDTH  writeback register
- wb_data_o  out  WORD_WIDTH  writeback value
- flags_o  out  4  {OF,SF,ZF,CF}
- busy_o  out  1  multiply in progress
- dbg_addr_i  in  ADDRESS_WIDTH  debug read address
- dbg_data_o  out  WORD_WIDTH  R[dbg_addr_i], combinational, post-writeback contents

Behaviour:
- Reset (arst_i=0, asynchronous):
  - all registers 0, flags_o=0, wb_valid_o=0, wb_addr_o=0, wb_data_o=0
  - FSM=IDLE, busy_o=0, issue_ready_o=1
  - reset during MUL aborts the multiply; no writeback is produced
- Register 0 reads as 0. Writes to it are discarded, but wb_valid_o is still reported.
- Opcodes:
  - 0 ADD, 1 ADC (A+B+CF), 2 SUB (A-B, CF=borrow), 3 AND, 4 OR, 5 XOR
  - 6 SHL, 7 SHR, 8 SAR: shift amount = B[log2(WORD_WIDTH)-1:0]
  - 9 MUL (low half), 10 MULH (unsigned high half), 11 MOV (result=B)
  - 12–15 NOP: accepted, no writeback, flags unchanged
- Flags:
  - ZF = result==0; SF = result MSB
  - ADD/ADC/SUB: CF = carry/borrow; OF = signed overflow
  - logic ops and MOV: CF=OF=0
  - shifts: CF = last bit shifted out (0 if amount 0); OF=0
  - MUL: CF=OF=(high half≠0)
  - MULH: CF=OF=0
- Handshake:
  - accept on rising edge where issue_valid_i && issue_ready_o
  - issue_ready_o = (FSM==IDLE)
  - inputs are sampled only at acceptance
- Single-cycle ops:
  - accepted at edge E; result and flags registered into the WB stage at E
  - wb_valid_o high for exactly the cycle after E
  - R[rd] and flags_o update at edge E+1
  - back-to-back issue at one op per cycle
- Forwarding:
  - if the WB stage is valid with wb_addr_o≠0 and equals ra_i or rb_i of the accepting op, use wb_data_o instead of the register file
  - ADC uses the WB stage's CF when WB is valid and was flag-producing
  - NOP does not forward
- MUL/MULH FSM, states IDLE→MUL→IDLE:
  - at acceptance, capture forwarded operands and load counter=WORD_WIDTH-1
  - MUL state: one shift-add step per cycle for WORD_WIDTH cycles; issue_ready_o=0, busy_o=1
  - on the final step edge: load WB stage, return to IDLE
  - wb_valid_o is high and issue_ready_o is high in the following cycle
  - total: accepted at E → wb_valid_o at cycle E+WORD_WIDTH+1
  - no writeback while in MUL; the WB stage clears after its one valid cycle
- Simultaneous writeback and debug read of the same register: dbg_data_o shows the old value until the write edge.

Decomposition:
- Package exec_pkg holds:
  - op_e enum (4-bit, values above)
  - flags_t packed struct {of,sf,zf,cf}
  - FLAG_* index constants
- One sub-module: exec_mul, the iterative unsigned shift-add multiplier.
  - Inputs: start, a, b. Outputs: done pulse, 2*WORD_WIDTH product.
  - Parametrised by WORD_WIDTH.
- ALU stays as a combinational function/always block inside exec_pipe.

Test Plan (WORD_WIDTH=8, ADDRESS_WIDTH=3):
- Reset, then issue MOV r1,imm=0x7F and ADD r2,r1,imm=0x01 back-to-back → second op forwards 0x7F; wb_data_o=0x80; flags_o: OF=1,SF=1,ZF=0,CF=0; dbg r2=0x80.
- SUB r3,r0,imm=0x01, then ADC r4,r0,imm=0x00 on the next cycle → r3=0xFF with CF=1; ADC uses forwarded CF → r4=0x01.
- MOV r5,0xFF, then MULH r6,r5,imm=0xFF → issue_ready_o low 8 cycles, busy_o=1; wb_valid_o 9 cycles after acceptance with r6=0xFE; a MUL with the same operands gives 0x01 with CF=OF=1.
- SHL r1,imm-source 0x81 via MOV, shift amount 1 → 0x02, CF=1; SAR of 0x80 by 7 → 0xFF, SF=1; shift by 0 → unchanged value, CF=0.
- Write to r0 (MOV r0,0x55) → wb_valid_o=1, wb_addr_o=0, dbg r0 reads 0; NOP opcode 13 → no wb_valid_o, flags unchanged.
- Assert arst_i low at cycle 3 of a MUL → immediate issue_ready_o=1, busy_o=0, flags_o=0, no wb_valid_o afterwards; all registers read 0.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared types for the exec_pipe execution pipeline: opcodes, flag layout and FSM states.
package exec_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADC  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_SAR  = 4'd8,
    OP_MUL  = 4'd9,
    OP_MULH = 4'd10,
    OP_MOV  = 4'd11,
    OP_NOP  = 4'd12
  } op_e;

  typedef struct packed {
    logic of;
    logic sf;
    logic zf;
    logic cf;
  } flags_t;

  localparam int FLAG_CF = 0;
  localparam int FLAG_ZF = 1;
  localparam int FLAG_SF = 2;
  localparam int FLAG_OF = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  // Opcodes 12..15 are all treated as NOP.
  function automatic logic is_nop(input logic [3:0] op);
    return op[3] & op[2];
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULH);
  endfunction

endpackage

// File: rtl/exec_pipe_if.sv
// Issue handshake and writeback bus between the instruction decoder and exec_pipe.
interface exec_pipe_if #(
  parameter int WORD_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 3
);

  logic                     issue_valid;
  logic                     issue_ready;
  logic [3:0]               op;
  logic [ADDRESS_WIDTH-1:0] rd;
  logic [ADDRESS_WIDTH-1:0] ra;
  logic [ADDRESS_WIDTH-1:0] rb;
  logic [WORD_WIDTH-1:0]    imm;
  logic                     use_imm;
  logic                     wb_valid;
  logic [ADDRESS_WIDTH-1:0] wb_addr;
  logic [WORD_WIDTH-1:0]    wb_data;

  modport master (
    output issue_valid, op, rd, ra, rb, imm, use_imm,
    input  issue_ready, wb_valid, wb_addr, wb_data
  );

  modport slave (
    input  issue_valid, op, rd, ra, rb, imm, use_imm,
    output issue_ready, wb_valid, wb_addr, wb_data
  );

endinterface

// File: rtl/exec_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, WORD_WIDTH steps.
// done_o marks the cycle whose step is the last one; product_o is then the final product.
module exec_mul
  import exec_pkg::*;
#(
  parameter int WORD_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    arst_i,
  input  logic                    start_i,
  input  logic [WORD_WIDTH-1:0]   a_i,
  input  logic [WORD_WIDTH-1:0]   b_i,
  output logic                    done_o,
  output logic [2*WORD_WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WORD_WIDTH);

  logic                    active_q, active_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [2*WORD_WIDTH-1:0] acc_q, acc_d;
  logic [2*WORD_WIDTH-1:0] mcand_q, mcand_d;
  logic [WORD_WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WORD_WIDTH-1:0] step_sum;

  always_comb begin
    step_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    done_o    = active_q && (cnt_q == '0);
    product_o = step_sum;

    active_d  = active_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;

    if (start_i) begin
      active_d = 1'b1;
      cnt_d    = CW'(WORD_WIDTH - 1);
      acc_d    = '0;
      mcand_d  = {{WORD_WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
    end else if (active_q) begin
      acc_d    = step_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      if (cnt_q == '0) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/exec_pipe.sv
// Single-issue execution pipeline: register file, ALU, WB stage with forwarding,
// and an IDLE/MUL FSM wrapping the iterative multiplier.
module exec_pipe
  import exec_pkg::*;
#(
  parameter int WORD_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 3
) (
  input  logic                     clk_i,
  input  logic                     arst_i,
  exec_pipe_if.slave               bus,
  output logic [3:0]               flags_o,
  output logic                     busy_o,
  input  logic [ADDRESS_WIDTH-1:0] dbg_addr_i,
  output logic [WORD_WIDTH-1:0]    dbg_data_o
);

  localparam int NREG = 2 ** ADDRESS_WIDTH;
  localparam int SHW  = $clog2(WORD_WIDTH);
  localparam int MSB  = WORD_WIDTH - 1;

  state_e                   state_q, state_d;
  logic [WORD_WIDTH-1:0]    rf_q [NREG];
  logic [WORD_WIDTH-1:0]    rf_d [NREG];
  flags_t                   flags_q, flags_d;
  logic                     wb_valid_q, wb_valid_d;
  logic [ADDRESS_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [WORD_WIDTH-1:0]    wb_data_q, wb_data_d;
  flags_t                   wb_flags_q, wb_flags_d;
  logic [3:0]               mul_op_q, mul_op_d;
  logic [ADDRESS_WIDTH-1:0] mul_rd_q, mul_rd_d;

  logic [WORD_WIDTH-1:0]    opa, opb;
  logic                     carry_in;
  logic [WORD_WIDTH-1:0]    alu_res;
  flags_t                   alu_flags;
  logic                     mul_start, mul_done;
  logic [2*WORD_WIDTH-1:0]  mul_product;
  logic [WORD_WIDTH-1:0]    mul_res;
  flags_t                   mul_flags;

  // The WB stage has not reached the register file yet, so it overrides it; r0 never forwards.
  always_comb begin
    opa = rf_q[bus.ra];
    opb = rf_q[bus.rb];
    if (wb_valid_q && (wb_addr_q != '0) && (wb_addr_q == bus.ra)) opa = wb_data_q;
    if (wb_valid_q && (wb_addr_q != '0) && (wb_addr_q == bus.rb)) opb = wb_data_q;
    if (bus.use_imm) opb = bus.imm;
    carry_in = wb_valid_q ? wb_flags_q.cf : flags_q.cf;
  end

  always_comb begin
    logic [WORD_WIDTH:0]        sum_ext;
    logic [WORD_WIDTH:0]        shl_ext;
    logic [WORD_WIDTH:0]        shr_ext;
    logic signed [WORD_WIDTH:0] sar_ext;
    logic [SHW-1:0]             sh;
    alu_res   = '0;
    alu_flags = '0;
    sh        = opb[SHW-1:0];
    sum_ext   = '0;
    // One extra bit catches the last bit shifted out, and stays 0 for a zero shift.
    shl_ext   = {1'b0, opa} << sh;
    shr_ext   = {opa, 1'b0} >> sh;
    sar_ext   = $signed({opa, 1'b0}) >>> sh;
    case (bus.op)
      OP_ADD, OP_ADC: begin
        sum_ext      = {1'b0, opa} + {1'b0, opb}
                     + {{WORD_WIDTH{1'b0}}, (bus.op == OP_ADC) && carry_in};
        alu_res      = sum_ext[WORD_WIDTH-1:0];
        alu_flags.cf = sum_ext[WORD_WIDTH];
        alu_flags.of = (opa[MSB] == opb[MSB]) && (alu_res[MSB] != opa[MSB]);
      end
      OP_SUB: begin
        sum_ext      = {1'b0, opa} - {1'b0, opb};
        alu_res      = sum_ext[WORD_WIDTH-1:0];
        alu_flags.cf = sum_ext[WORD_WIDTH];
        alu_flags.of = (opa[MSB] != opb[MSB]) && (alu_res[MSB] != opa[MSB]);
      end
      OP_AND: alu_res = opa & opb;
      OP_OR:  alu_res = opa | opb;
      OP_XOR: alu_res = opa ^ opb;
      OP_MOV: alu_res = opb;
      OP_SHL: begin
        alu_res      = shl_ext[WORD_WIDTH-1:0];
        alu_flags.cf = shl_ext[WORD_WIDTH];
      end
      OP_SHR: begin
        alu_res      = shr_ext[WORD_WIDTH:1];
        alu_flags.cf = shr_ext[0];
      end
      OP_SAR: begin
        alu_res      = sar_ext[WORD_WIDTH:1];
        alu_flags.cf = sar_ext[0];
      end
      default: ;
    endcase
    alu_flags.zf = (alu_res == '0);
    alu_flags.sf = alu_res[MSB];
  end

  always_comb begin
    mul_res      = (mul_op_q == OP_MULH) ? mul_product[2*WORD_WIDTH-1:WORD_WIDTH]
                                         : mul_product[WORD_WIDTH-1:0];
    mul_flags    = '0;
    mul_flags.zf = (mul_res == '0);
    mul_flags.sf = mul_res[MSB];
    mul_flags.cf = (mul_op_q == OP_MUL) && (mul_product[2*WORD_WIDTH-1:WORD_WIDTH] != '0);
    mul_flags.of = mul_flags.cf;
  end

  always_comb begin
    rf_d = rf_q;
    if (wb_valid_q && (wb_addr_q != '0)) rf_d[wb_addr_q] = wb_data_q;
    flags_d = wb_valid_q ? wb_flags_q : flags_q;
  end

  always_comb begin
    state_d    = state_q;
    wb_valid_d = 1'b0;
    wb_addr_d  = '0;
    wb_data_d  = '0;
    wb_flags_d = wb_flags_q;
    mul_op_d   = mul_op_q;
    mul_rd_d   = mul_rd_q;
    mul_start  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.issue_valid) begin
          if (is_mul(bus.op)) begin
            mul_start = 1'b1;
            mul_op_d  = bus.op;
            mul_rd_d  = bus.rd;
            state_d   = ST_MUL;
          end else if (!is_nop(bus.op)) begin
            wb_valid_d = 1'b1;
            wb_addr_d  = bus.rd;
            wb_data_d  = alu_res;
            wb_flags_d = alu_flags;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          wb_valid_d = 1'b1;
          wb_addr_d  = mul_rd_q;
          wb_data_d  = mul_res;
          wb_flags_d = mul_flags;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q    <= ST_IDLE;
      rf_q       <= '{default: '0};
      flags_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      wb_flags_q <= '0;
      mul_op_q   <= '0;
      mul_rd_q   <= '0;
    end else begin
      state_q    <= state_d;
      rf_q       <= rf_d;
      flags_q    <= flags_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      wb_flags_q <= wb_flags_d;
      mul_op_q   <= mul_op_d;
      mul_rd_q   <= mul_rd_d;
    end
  end

  exec_mul #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_mul (
    .clk_i     (clk_i),
    .arst_i    (arst_i),
    .start_i   (mul_start),
    .a_i       (opa),
    .b_i       (opb),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  assign bus.issue_ready = (state_q == ST_IDLE);
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_addr     = wb_addr_q;
  assign bus.wb_data     = wb_data_q;
  assign flags_o         = flags_q;
  assign busy_o          = (state_q == ST_MUL);
  assign dbg_data_o      = rf_q[dbg_addr_i];

endmodule

// File: tb/tb_exec_pipe.sv
// Directed bench for exec_pipe (WORD_WIDTH=8, ADDRESS_WIDTH=3); inputs change and
// outputs are sampled on the falling clock edge.
module tb_exec_pipe;

  localparam int WW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          arst = 1'b0;
  logic [3:0]    flags;
  logic          busy;
  logic [AW-1:0] dbg_addr = '0;
  logic [WW-1:0] dbg_data;

  int vectors = 0;
  int miscompares = 0;

  exec_pipe_if #(.WORD_WIDTH(WW), .ADDRESS_WIDTH(AW)) bus ();

  exec_pipe #(
    .WORD_WIDTH    (WW),
    .ADDRESS_WIDTH (AW)
  ) dut (
    .clk_i      (clk),
    .arst_i     (arst),
    .bus        (bus),
    .flags_o    (flags),
    .busy_o     (busy),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                       input logic [2:0] rb, input logic [7:0] imm, input logic use_imm);
    bus.issue_valid = 1'b1;
    bus.op          = op;
    bus.rd          = rd;
    bus.ra          = ra;
    bus.rb          = rb;
    bus.imm         = imm;
    bus.use_imm     = use_imm;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.op          = 4'd12;
    bus.use_imm     = 1'b0;
  endtask

  task automatic test_reset();
    arst = 1'b0;
    idle();
    bus.rd = '0; bus.ra = '0; bus.rb = '0; bus.imm = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.issue_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready: got %b want 1", bus.issue_ready); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    vectors++;
    if (flags !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_flags: got %b want 0000", flags); end
    vectors++;
    if ({bus.wb_valid, bus.wb_addr, bus.wb_data} !== 12'h000) begin
      miscompares++; $display("[TB] FAIL reset_wb: got v=%b a=%0d d=%h want all 0", bus.wb_valid, bus.wb_addr, bus.wb_data);
    end
    arst = 1'b1;
  endtask

  task automatic test_forward_add();
    @(negedge clk); drive(4'd11, 3'd1, 3'd0, 3'd0, 8'h7F, 1'b1);
    @(negedge clk);
    vectors++;
    if (bus.wb_valid !== 1'b1 || bus.wb_data !== 8'h7F) begin
      miscompares++; $display("[TB] FAIL mov_wb: got v=%b d=%h want v=1 d=7f", bus.wb_valid, bus.wb_data);
    end
    drive(4'd0, 3'd2, 3'd1, 3'd0, 8'h01, 1'b1);
    @(negedge clk); idle();
    vectors++;
    if (bus.wb_addr !== 3'd2 || bus.wb_data !== 8'h80) begin
      miscompares++; $display("[TB] FAIL add_fwd: got a=%0d d=%h want a=2 d=80", bus.wb_addr, bus.wb_data);
    end
    dbg_addr = 3'd2; #1;
    vectors++;
    if (dbg_data !== 8'h00) begin miscompares++; $display("[TB] FAIL dbg_before_write: got %h want 00", dbg_data); end
    @(negedge clk);
    vectors++;
    if (flags !== 4'b1100) begin miscompares++; $display("[TB] FAIL add_flags: got %b want 1100", flags); end
    vectors++;
    if (dbg_data !== 8'h80) begin miscompares++; $display("[TB] FAIL dbg_r2: got %h want 80", dbg_data); end
    vectors++;
    if (bus.wb_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL wb_one_cycle: got %b want 0", bus.wb_valid); end
  endtask

  task automatic test_sub_adc();
    @(negedge clk); drive(4'd2, 3'd3, 3'd0, 3'd0, 8'h01, 1'b1);
    @(negedge clk);
    vectors++;
    if (bus.wb_data !== 8'hFF) begin miscompares++; $display("[TB] FAIL sub_data: got %h want ff", bus.wb_data); end
    drive(4'd1, 3'd4, 3'd0, 3'd0, 8'h00, 1'b1);
    @(negedge clk); idle();
    vectors++;
    if (bus.wb_data !== 8'h01) begin miscompares++; $display("[TB] FAIL adc_fwd_cf: got %h want 01", bus.wb_data); end
    vectors++;
    if (flags !== 4'b0101) begin miscompares++; $display("[TB] FAIL sub_flags: got %b want 0101", flags); end
    @(negedge clk);
    vectors++;
    if (flags !== 4'b0000) begin miscompares++; $display("[TB] FAIL adc_flags: got %b want 0000", flags); end
    dbg_addr = 3'd3; #1;
    vectors++;
    if (dbg_data !== 8'hFF) begin miscompares++; $display("[TB] FAIL dbg_r3: got %h want ff", dbg_data); end
    dbg_addr = 3'd4; #1;
    vectors++;
    if (dbg_data !== 8'h01) begin miscompares++; $display("[TB] FAIL dbg_r4: got %h want 01", dbg_data); end
  endtask

  task automatic test_mul();
    int stall_err = 0;
    int lat = 0;
    @(negedge clk); drive(4'd11, 3'd5, 3'd0, 3'd0, 8'hFF, 1'b1);
    @(negedge clk); drive(4'd10, 3'd6, 3'd5, 3'd0, 8'hFF, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) idle();
      if (bus.issue_ready !== 1'b0 || busy !== 1'b1 || bus.wb_valid !== 1'b0) stall_err++;
    end
    vectors++;
    if (stall_err !== 0) begin miscompares++; $display("[TB] FAIL mulh_stall: got %0d bad cycles want 0", stall_err); end
    @(negedge clk);
    vectors++;
    if (bus.wb_valid !== 1'b1 || bus.wb_addr !== 3'd6 || bus.wb_data !== 8'hFE) begin
      miscompares++; $display("[TB] FAIL mulh_wb: got v=%b a=%0d d=%h want v=1 a=6 d=fe", bus.wb_valid, bus.wb_addr, bus.wb_data);
    end
    vectors++;
    if (bus.issue_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("[TB] FAIL mulh_done_ready: got rdy=%b busy=%b want 1 0", bus.issue_ready, busy);
    end
    drive(4'd9, 3'd7, 3'd5, 3'd0, 8'hFF, 1'b1);
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        idle();
        vectors++;
        if (flags !== 4'b0100) begin miscompares++; $display("[TB] FAIL mulh_flags: got %b want 0100", flags); end
      end
    end while (bus.wb_valid !== 1'b1 && lat < 20);
    vectors++;
    if (lat !== 9) begin miscompares++; $display("[TB] FAIL mul_latency: got %0d want 9", lat); end
    vectors++;
    if (bus.wb_data !== 8'h01 || bus.wb_addr !== 3'd7) begin
      miscompares++; $display("[TB] FAIL mul_wb: got a=%0d d=%h want a=7 d=01", bus.wb_addr, bus.wb_data);
    end
    @(negedge clk);
    vectors++;
    if (flags !== 4'b1001) begin miscompares++; $display("[TB] FAIL mul_flags: got %b want 1001", flags); end
    dbg_addr = 3'd6; #1;
    vectors++;
    if (dbg_data !== 8'hFE) begin miscompares++; $display("[TB] FAIL dbg_r6: got %h want fe", dbg_data); end
  endtask

  task automatic test_shift();
    @(negedge clk); drive(4'd11, 3'd1, 3'd0, 3'd0, 8'h81, 1'b1);
    @(negedge clk);
    vectors++;
    if (bus.wb_data !== 8'h81) begin miscompares++; $display("[TB] FAIL mov81: got %h want 81", bus.wb_data); end
    drive(4'd6, 3'd2, 3'd1, 3'd0, 8'h01, 1'b1);
    @(negedge clk);
    vectors++;
    if (bus.wb_data !== 8'h02) begin miscompares++; $display("[TB] FAIL shl1_data: got %h want 02", bus.wb_data); end
    vectors++;
    if (flags !== 4'b0100) begin miscompares++; $display("[TB] FAIL mov81_flags: got %b want 0100", flags); end
    drive(4'd6, 3'd5, 3'd1, 3'd0, 8'h00, 1'b1);
    @(negedge clk);
    vectors++;
    if (bus.wb_data !== 8'h81) begin miscompares++; $display("[TB] FAIL shl0_data: got %h want 81", bus.wb_data); end
    vectors++;
    if (flags !== 4'b0001) begin miscompares++; $display("[TB] FAIL shl1_flags: got %b want 0001", flags); end
    drive(4'd11, 3'd3, 3'd0, 3'd0, 8'h80, 1'b1);
    @(negedge clk);
    vectors++;
    if (flags !== 4'b0100) begin miscompares++; $display("[TB] FAIL shl0_flags: got %b want 0100", flags); end
    drive(4'd8, 3'd4, 3'd3, 3'd0, 8'h07, 1'b1);
    @(negedge clk);
    vectors++;
    if (bus.wb_data !== 8'hFF) begin miscompares++; $display("[TB] FAIL sar7_data: got %h want ff", bus.wb_data); end
    drive(4'd7, 3'd6, 3'd4, 3'd0, 8'h04, 1'b1);
    @(negedge clk); idle();
    vectors++;
    if (bus.wb_data !== 8'h0F) begin miscompares++; $display("[TB] FAIL shr4_data: got %h want 0f", bus.wb_data); end
    vectors++;
    if (flags !== 4'b0100) begin miscompares++; $display("[TB] FAIL sar7_flags: got %b want 0100", flags); end
    @(negedge clk);
    vectors++;
    if (flags !== 4'b0001) begin miscompares++; $display("[TB] FAIL shr4_flags: got %b want 0001", flags); end
  endtask

  task automatic test_r0_nop();
    @(negedge clk); drive(4'd13, 3'd1, 3'd0, 3'd0, 8'hAA, 1'b1);
    @(negedge clk);
    vectors++;
    if (bus.wb_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL nop_wb: got %b want 0", bus.wb_valid); end
    drive(4'd11, 3'd0, 3'd0, 3'd0, 8'h55, 1'b1);
    @(negedge clk);
    vectors++;
    if (bus.wb_valid !== 1'b1 || bus.wb_addr !== 3'd0 || bus.wb_data !== 8'h55) begin
      miscompares++; $display("[TB] FAIL r0_wb: got v=%b a=%0d d=%h want v=1 a=0 d=55", bus.wb_valid, bus.wb_addr, bus.wb_data);
    end
    vectors++;
    if (flags !== 4'b0001) begin miscompares++; $display("[TB] FAIL nop_flags: got %b want 0001", flags); end
    drive(4'd0, 3'd7, 3'd0, 3'd0, 8'h01, 1'b1);
    @(negedge clk); idle();
    vectors++;
    if (bus.wb_data !== 8'h01) begin miscompares++; $display("[TB] FAIL r0_no_fwd: got %h want 01", bus.wb_data); end
    vectors++;
    if (flags !== 4'b0000) begin miscompares++; $display("[TB] FAIL mov55_flags: got %b want 0000", flags); end
    dbg_addr = 3'd0; #1;
    vectors++;
    if (dbg_data !== 8'h00) begin miscompares++; $display("[TB] FAIL dbg_r0: got %h want 00", dbg_data); end
    dbg_addr = 3'd1; #1;
    vectors++;
    if (dbg_data !== 8'h81) begin miscompares++; $display("[TB] FAIL nop_no_write: got %h want 81", dbg_data); end
  endtask

  task automatic test_reset_mul();
    int wb_seen = 0;
    @(negedge clk); drive(4'd2, 3'd2, 3'd0, 3'd0, 8'h01, 1'b1);
    @(negedge clk); drive(4'd9, 3'd1, 3'd5, 3'd0, 8'h03, 1'b1);
    @(negedge clk); idle();
    @(negedge clk);
    vectors++;
    if (flags !== 4'b0101 || busy !== 1'b1) begin
      miscompares++; $display("[TB] FAIL pre_reset: got flags=%b busy=%b want 0101 1", flags, busy);
    end
    @(negedge clk);
    arst = 1'b0; #1;
    vectors++;
    if (bus.issue_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("[TB] FAIL abort_state: got rdy=%b busy=%b want 1 0", bus.issue_ready, busy);
    end
    vectors++;
    if (flags !== 4'b0000 || bus.wb_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL abort_flags_wb: got flags=%b v=%b want 0000 0", flags, bus.wb_valid);
    end
    @(negedge clk); arst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.wb_valid !== 1'b0) wb_seen++;
    end
    vectors++;
    if (wb_seen !== 0) begin miscompares++; $display("[TB] FAIL abort_no_wb: got %0d wb cycles want 0", wb_seen); end
    for (int r = 0; r < 8; r++) begin
      dbg_addr = 3'(r); #1;
      vectors++;
      if (dbg_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_reg%0d: got %h want 00", r, dbg_data); end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_forward_add();
    test_sub_adc();
    test_mul();
    test_shift();
    test_r0_nop();
    test_reset_mul();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
